// File: rtl/mini_unpack_fsm.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mini_unpack_fsm
//
// Byte-pair unpacker. Words of 2*BYTE_W bits are loaded into a small input
// RAM while the block is idle. A start request runs an FSM that reads each
// word, splits it into two bytes and emits them one per cycle through a
// RAM-style write port. A single-cycle done pulse marks the end of the run.
//
// Ports (AW = $clog2(WORDS)):
//   clk              in   1         system clock, rising edge
//   rst_n            in   1         asynchronous active-low reset
//   start            in   1         run request, level, sampled only in IDLE
//   ram_in_we        in   1         input RAM write enable (honoured in IDLE)
//   ram_in_addr_wr   in   AW        input RAM word address
//   ram_in_data_wr   in   2*BYTE_W  input RAM write data
//   ram_out_we       out  1         byte write strobe, one byte per cycle
//   ram_out_addr_wr  out  AW+1      byte address {word_idx, byte_sel}
//   ram_out_data_wr  out  BYTE_W    byte data
//   busy             out  1         high from start acceptance until back in IDLE
//   done             out  1         one-cycle pulse at the end of a run
// ---------------------------------------------------------------------------
module mini_unpack_fsm #(
  parameter int WORDS    = 2,
  parameter int BYTE_W   = 8,
  parameter int HI_FIRST = 0,
  localparam int AW      = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  ram_in_we,
  input  logic [AW-1:0]         ram_in_addr_wr,
  input  logic [2*BYTE_W-1:0]   ram_in_data_wr,
  output logic                  ram_out_we,
  output logic [AW:0]           ram_out_addr_wr,
  output logic [BYTE_W-1:0]     ram_out_data_wr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WR_LO,
    S_WR_HI,
    S_DONE
  } state_t;

  logic [2*BYTE_W-1:0] mem [WORDS];

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [2*BYTE_W-1:0] hold_q, hold_d;
  logic                we_q, we_d;
  logic [AW:0]         addr_q, addr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [2*BYTE_W-1:0] rd_word;
  logic [BYTE_W-1:0]   rd_first;
  logic [BYTE_W-1:0]   hold_second;

  // Input RAM: no reset so contents survive rst_n; writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (ram_in_we && (state_q == S_IDLE)) begin
      mem[ram_in_addr_wr] <= ram_in_data_wr;
    end
  end

  // The byte emitted first comes straight from the RAM on the edge leaving
  // READ (same edge that fills the holding register); the second byte comes
  // from the holding register one cycle later.
  assign rd_word     = mem[idx_q];
  assign rd_first    = (HI_FIRST != 0) ? rd_word[2*BYTE_W-1:BYTE_W] : rd_word[BYTE_W-1:0];
  assign hold_second = (HI_FIRST != 0) ? hold_q[BYTE_W-1:0] : hold_q[2*BYTE_W-1:BYTE_W];

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that the registered outputs line up with that state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    we_d    = 1'b0;
    addr_d  = '0;
    data_d  = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          busy_d  = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_WR_LO;
        hold_d  = rd_word;
        we_d    = 1'b1;
        addr_d  = {idx_q, 1'b0};
        data_d  = rd_first;
      end
      S_WR_LO: begin
        state_d = S_WR_HI;
        we_d    = 1'b1;
        addr_d  = {idx_q, 1'b1};
        data_d  = hold_second;
      end
      S_WR_HI: begin
        // idx stops at the last word so the RAM is never addressed out of range
        if (idx_q == AW'(WORDS - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_READ;
          idx_d   = idx_q + AW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any run without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram_out_we      = we_q;
  assign ram_out_addr_wr = addr_q;
  assign ram_out_data_wr = data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule
